// File: rtl/tq_premuat_pipe_pkg.sv
// Shared definitions for the TQ butterfly permutation pipe.
//   TS_4..TS_32 : transform-size encodings carried on in_transize
//   DATA_W_DEF  : default signed coefficient width per lane
//   state_e     : row-framing FSM states
//   size_of()   : transform size S = 4 << ts
package tq_pkg;

    localparam logic [1:0] TS_4  = 2'd0;
    localparam logic [1:0] TS_8  = 2'd1;
    localparam logic [1:0] TS_16 = 2'd2;
    localparam logic [1:0] TS_32 = 2'd3;

    localparam int unsigned DATA_W_DEF = 28;

    typedef enum logic [0:0] {
        StIdle,
        StBlock
    } state_e;

    function automatic int unsigned size_of(input logic [1:0] ts);
        return 32'd4 << ts;
    endfunction

endpackage

// File: rtl/tq_premuat_pipe_if.sv
// Row stream bundle between the transpose buffer, the permutation pipe and
// the butterfly array.
//   in_*  : upstream row (valid/ready, sop, mode, data)
//   out_* : downstream row (valid/ready, data, sop/eop/err tags)
//   master: the side that drives rows in and consumes rows out
//   slave : the permutation pipe itself
interface tq_premuat_pipe_if #(
    parameter int unsigned DATA_W = 28,
    parameter int unsigned LANES  = 32
);

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sop;
    logic                    in_inverse;
    logic [1:0]              in_transize;
    logic [LANES*DATA_W-1:0] in_data;

    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic                    out_sop;
    logic                    out_eop;
    logic                    out_err;

    modport master (
        output in_valid, in_sop, in_inverse, in_transize, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_err
    );

    modport slave (
        input  in_valid, in_sop, in_inverse, in_transize, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_err
    );

endinterface

// File: rtl/tq_premuat_pipe_stage.sv
// One combinational permutation layer: D_K (deinterleave) or I_K (interleave)
// applied independently inside every aligned K-lane segment.
//   i_en      : 0 passes the row through untouched
//   i_inverse : 0 = D_K, 1 = I_K
//   i_data    : row in, lane i at [i*DATA_W +: DATA_W]
//   o_data    : permuted row
module tq_premuat_stage #(
    parameter int unsigned K      = 8,
    parameter int unsigned LANES  = 32,
    parameter int unsigned DATA_W = 28
) (
    input  logic                    i_en,
    input  logic                    i_inverse,
    input  logic [LANES*DATA_W-1:0] i_data,
    output logic [LANES*DATA_W-1:0] o_data
);

    localparam int unsigned H = K / 2;

    logic [LANES*DATA_W-1:0] w_dil;
    logic [LANES*DATA_W-1:0] w_ilv;

    // Pure wiring: even lanes of a segment go to its lower half, odd to the upper.
    always_comb begin
        w_dil = '0;
        w_ilv = '0;
        for (int b = 0; b < int'(LANES); b += int'(K)) begin
            for (int j = 0; j < int'(H); j++) begin
                w_dil[(b+j)*DATA_W +: DATA_W]       = i_data[(b+2*j)*DATA_W +: DATA_W];
                w_dil[(b+int'(H)+j)*DATA_W +: DATA_W] = i_data[(b+2*j+1)*DATA_W +: DATA_W];
                w_ilv[(b+2*j)*DATA_W +: DATA_W]     = i_data[(b+j)*DATA_W +: DATA_W];
                w_ilv[(b+2*j+1)*DATA_W +: DATA_W]   = i_data[(b+int'(H)+j)*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            o_data = i_inverse ? w_ilv : w_dil;
        end
    end

endmodule

// File: rtl/tq_premuat_pipe.sv
// Two-stage elastic butterfly permutation pipe with block framing.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the row stream (in_* rows in, out_* rows out)
// Register A holds the row after all but the last permutation layer of its
// direction; register B holds the finished row and drives the outputs.
module tq_premuat_pipe
    import tq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LANES  = 32
) (
    input logic              clk,
    input logic              rst_n,
    tq_premuat_pipe_if.slave bus
);

    localparam int unsigned W      = LANES * DATA_W;
    localparam int unsigned NSTG   = $clog2(LANES) - 2;
    localparam int unsigned NFRONT = NSTG - 1;
    localparam int unsigned CNT_W  = $clog2(LANES);

    // Handshake
    logic r_a_valid, r_b_valid;
    logic w_b_ready, w_in_ready, w_in_fire;

    assign w_b_ready  = ~r_b_valid | bus.out_ready;
    assign w_in_ready = ~r_a_valid | w_b_ready;
    assign w_in_fire  = bus.in_valid & w_in_ready;

    // Framing FSM and mode latch
    state_e           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_last;
    logic             r_inv, w_inv_nx, w_row_inv;
    logic [1:0]       r_ts, w_ts_nx, w_row_ts;
    logic             w_tag_eop, w_tag_err;

    assign w_last = CNT_W'(size_of(r_ts) - 1);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_inv_nx   = r_inv;
        w_ts_nx    = r_ts;
        w_tag_eop  = 1'b0;
        w_tag_err  = 1'b0;
        // A sop row already uses its own mode; other rows use the latched one.
        w_row_inv  = bus.in_sop ? bus.in_inverse : r_inv;
        w_row_ts   = bus.in_sop ? bus.in_transize : r_ts;
        if (w_in_fire) begin
            if (bus.in_sop) begin
                w_inv_nx   = bus.in_inverse;
                w_ts_nx    = bus.in_transize;
                w_state_nx = StBlock;
                w_cnt_nx   = CNT_W'(1);
                w_tag_err  = (r_state == StBlock);
            end else begin
                unique case (r_state)
                    StIdle: w_tag_err = 1'b1;
                    StBlock: begin
                        if (r_cnt == w_last) begin
                            w_tag_eop  = 1'b1;
                            w_state_nx = StIdle;
                            w_cnt_nx   = '0;
                        end else begin
                            w_cnt_nx = r_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
            r_ts    <= TS_4;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_inv   <= w_inv_nx;
            r_ts    <= w_ts_nx;
        end
    end

    // Front layers: forward D_8..D_{LANES/2}, inverse I_LANES..I_16
    logic [31:0]  w_size_in, w_size_a;
    logic [W-1:0] w_fwd [NFRONT+1];
    logic [W-1:0] w_inv [NFRONT+1];
    logic [W-1:0] w_a_in, w_b_fwd, w_b_inv, w_b_in;

    assign w_size_in = size_of(w_row_ts);
    assign w_fwd[0]  = bus.in_data;
    assign w_inv[0]  = bus.in_data;

    for (genvar s = 0; s < NFRONT; s++) begin : g_front
        localparam int unsigned KF = 8 << s;
        localparam int unsigned KI = LANES >> s;
        tq_premuat_stage #(.K(KF), .LANES(LANES), .DATA_W(DATA_W)) u_fwd (
            .i_en      (KF <= w_size_in),
            .i_inverse (1'b0),
            .i_data    (w_fwd[s]),
            .o_data    (w_fwd[s+1])
        );
        tq_premuat_stage #(.K(KI), .LANES(LANES), .DATA_W(DATA_W)) u_inv (
            .i_en      (KI <= w_size_in),
            .i_inverse (1'b1),
            .i_data    (w_inv[s]),
            .o_data    (w_inv[s+1])
        );
    end

    assign w_a_in = w_row_inv ? w_inv[NFRONT] : w_fwd[NFRONT];

    // Stage A registers
    logic [W-1:0] r_a_data;
    logic         r_a_sop, r_a_eop, r_a_err, r_a_inv;
    logic [1:0]   r_a_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
            r_a_sop   <= 1'b0;
            r_a_eop   <= 1'b0;
            r_a_err   <= 1'b0;
            r_a_inv   <= 1'b0;
            r_a_ts    <= TS_4;
        end else begin
            if (w_in_ready) r_a_valid <= bus.in_valid;
            if (w_in_fire) begin
                r_a_data <= w_a_in;
                r_a_sop  <= bus.in_sop;
                r_a_eop  <= w_tag_eop;
                r_a_err  <= w_tag_err;
                r_a_inv  <= w_row_inv;
                r_a_ts   <= w_row_ts;
            end
        end
    end

    // Last layer: forward D_LANES, inverse I_8
    assign w_size_a = size_of(r_a_ts);

    tq_premuat_stage #(.K(LANES), .LANES(LANES), .DATA_W(DATA_W)) u_back_fwd (
        .i_en      (LANES <= w_size_a),
        .i_inverse (1'b0),
        .i_data    (r_a_data),
        .o_data    (w_b_fwd)
    );

    tq_premuat_stage #(.K(8), .LANES(LANES), .DATA_W(DATA_W)) u_back_inv (
        .i_en      (32'd8 <= w_size_a),
        .i_inverse (1'b1),
        .i_data    (r_a_data),
        .o_data    (w_b_inv)
    );

    assign w_b_in = r_a_inv ? w_b_inv : w_b_fwd;

    // Stage B registers drive the outputs and hold while stalled
    logic [W-1:0] r_b_data;
    logic         r_b_sop, r_b_eop, r_b_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
            r_b_sop   <= 1'b0;
            r_b_eop   <= 1'b0;
            r_b_err   <= 1'b0;
        end else if (w_b_ready) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_b_data <= w_b_in;
                r_b_sop  <= r_a_sop;
                r_b_eop  <= r_a_eop;
                r_b_err  <= r_a_err;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_b_valid;
    assign bus.out_data  = r_b_data;
    assign bus.out_sop   = r_b_sop;
    assign bus.out_eop   = r_b_eop;
    assign bus.out_err   = r_b_err;

endmodule

// File: tb/tb_tq_premuat_pipe.sv
// Self-checking bench for tq_premuat_pipe: table of framed rows, hand-written
// lane-order / roundtrip / reset sequences, and a randomly back-pressured run.
module tb_tq_premuat_pipe;
    import tq_pkg::*;

    localparam int unsigned DW = 28;
    localparam int unsigned LN = 32;
    localparam int unsigned W  = DW * LN;

    typedef logic [W-1:0] data_t;

    typedef struct {
        data_t data;
        logic  sop;
        logic  eop;
        logic  err;
        int    acc_cyc;
    } exp_t;

    typedef struct {
        logic       sop;
        logic       inv;
        logic [1:0] ts;
        int         dsel;
        logic       e_sop;
        logic       e_eop;
        logic       e_err;
        logic       e_inv;
        logic [1:0] e_ts;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tq_premuat_pipe_if #(.DATA_W(DW), .LANES(LN)) bus ();

    tq_premuat_pipe #(.DATA_W(DW), .LANES(LN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    n_pop = 0;
    exp_t  sb [$];
    exp_t  cur_exp;
    logic  acc;
    bit    lat_chk = 1'b1;
    bit    rand_rdy = 1'b0;
    logic  held_v = 1'b0;
    data_t held_d;
    logic [2:0] held_t;
    data_t last_data;
    vec_t  vt [$];

    task automatic check(input string name, input data_t got, input data_t want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Reference: build the forward lane map from D_8..D_S, inverse uses its inverse map.
    function automatic data_t model(input data_t d, input logic inv, input logic [1:0] ts);
        int    p [LN];
        int    t [LN];
        int    s;
        data_t r;
        s = 4 << ts;
        for (int i = 0; i < LN; i++) p[i] = i;
        for (int k = 8; k <= LN; k = k * 2) begin
            if (k <= s) begin
                for (int b = 0; b < LN; b += k) begin
                    for (int j = 0; j < k / 2; j++) begin
                        t[b+j]       = p[b+2*j];
                        t[b+k/2+j]   = p[b+2*j+1];
                    end
                end
                p = t;
            end
        end
        r = '0;
        for (int i = 0; i < LN; i++) begin
            if (!inv) r[i*DW +: DW] = d[p[i]*DW +: DW];
            else      r[p[i]*DW +: DW] = d[i*DW +: DW];
        end
        return r;
    endfunction

    function automatic data_t idx_data();
        data_t d;
        for (int i = 0; i < LN; i++) d[i*DW +: DW] = DW'(i);
        return d;
    endfunction

    function automatic data_t rnd_data();
        data_t d;
        for (int i = 0; i < LN; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    // One clock: sample at negedge, then advance to just after the next posedge.
    task automatic step();
        exp_t e;
        acc = 1'b0;
        @(negedge clk);
        if (held_v) begin
            check("stall_valid_hold", data_t'(bus.out_valid), data_t'(1'b1));
            check("stall_data_hold", bus.out_data, held_d);
            check("stall_tag_hold", data_t'({bus.out_sop, bus.out_eop, bus.out_err}),
                  data_t'(held_t));
        end
        held_v = bus.out_valid & ~bus.out_ready;
        held_d = bus.out_data;
        held_t = {bus.out_sop, bus.out_eop, bus.out_err};
        if (bus.out_valid && bus.out_ready) begin
            n_pop++;
            last_data = bus.out_data;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got a row, expected none");
            end else begin
                e = sb.pop_front();
                check("out_data", bus.out_data, e.data);
                check("out_sop", data_t'(bus.out_sop), data_t'(e.sop));
                check("out_eop", data_t'(bus.out_eop), data_t'(e.eop));
                check("out_err", data_t'(bus.out_err), data_t'(e.err));
                if (lat_chk) check("latency", data_t'(cyc - e.acc_cyc), data_t'(2));
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e = cur_exp;
            e.acc_cyc = cyc;
            sb.push_back(e);
            acc = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_row(input logic sop, input logic inv, input logic [1:0] ts,
                             input data_t d, input logic es, input logic ee, input logic er,
                             input logic ei, input logic [1:0] et);
        int n;
        n = 0;
        bus.in_valid    = 1'b1;
        bus.in_sop      = sop;
        bus.in_inverse  = inv;
        bus.in_transize = ts;
        bus.in_data     = d;
        cur_exp.data = model(d, ei, et);
        cur_exp.sop  = es;
        cur_exp.eop  = ee;
        cur_exp.err  = er;
        do begin
            step();
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (sb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_empty", data_t'(sb.size()), '0);
    endtask

    task automatic add_vec(input logic sop, input logic inv, input logic [1:0] ts, input int dsel,
                           input logic es, input logic ee, input logic er, input logic ei,
                           input logic [1:0] et);
        vec_t v;
        v.sop = sop; v.inv = inv; v.ts = ts; v.dsel = dsel;
        v.e_sop = es; v.e_eop = ee; v.e_err = er; v.e_inv = ei; v.e_ts = et;
        vt.push_back(v);
    endtask

    // Rows after the first present junk mode inputs, which must be ignored.
    task automatic add_block(input logic inv, input logic [1:0] ts, input int rows,
                             input logic first_err, input int dsel);
        int s;
        s = 4 << ts;
        for (int r = 0; r < rows; r++) begin
            add_vec(r == 0, (r == 0) ? inv : ~inv, (r == 0) ? ts : ~ts, dsel,
                    r == 0, r == s - 1, (r == 0) && first_err, inv, ts);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        data_t d;
        data_t y;
        int    exp8 [16];
        int    exp16 [8];
        int    nrow;
        int    pop0;
        int    s;
        logic [1:0] rts;
        logic  rinv;

        exp8  = '{0, 2, 4, 6, 1, 3, 5, 7, 8, 10, 12, 14, 9, 11, 13, 15};
        exp16 = '{0, 4, 1, 5, 8, 12, 9, 13};

        rst_n           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_sop      = 1'b0;
        bus.in_inverse  = 1'b0;
        bus.in_transize = TS_4;
        bus.in_data     = '0;
        bus.out_ready   = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_out_valid", data_t'(bus.out_valid), '0);
        check("reset_out_tags", data_t'({bus.out_sop, bus.out_eop, bus.out_err}), '0);
        check("reset_out_data", bus.out_data, '0);
        check("reset_in_ready", data_t'(bus.in_ready), data_t'(1'b1));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Framing table
        add_block(1'b0, TS_8, 8, 1'b0, 0);
        add_block(1'b1, TS_4, 4, 1'b0, 1);
        add_block(1'b0, TS_4, 4, 1'b0, 1);
        add_block(1'b0, TS_8, 4, 1'b0, 1);
        add_block(1'b0, TS_8, 8, 1'b1, 1);
        add_block(1'b1, TS_32, 32, 1'b0, 1);
        add_block(1'b0, TS_16, 16, 1'b0, 1);
        add_vec(1'b0, 1'b1, TS_4, 1, 1'b0, 1'b0, 1'b1, 1'b0, TS_16);
        add_block(1'b1, TS_16, 16, 1'b0, 1);
        foreach (vt[i]) begin
            d = (vt[i].dsel == 0) ? idx_data() : rnd_data();
            drive_row(vt[i].sop, vt[i].inv, vt[i].ts, d, vt[i].e_sop, vt[i].e_eop,
                      vt[i].e_err, vt[i].e_inv, vt[i].e_ts);
        end
        drain();

        // Lane order for S=8 forward
        drive_row(1'b1, 1'b0, TS_8, idx_data(), 1'b1, 1'b0, 1'b0, 1'b0, TS_8);
        drain();
        for (int i = 0; i < 16; i++)
            check("fwd8_lane", data_t'(last_data[i*DW +: DW]), data_t'(exp8[i]));

        // S=16 forward then inverse back to the original
        drive_row(1'b1, 1'b0, TS_16, idx_data(), 1'b1, 1'b0, 1'b1, 1'b0, TS_16);
        drain();
        for (int i = 0; i < 8; i++)
            check("fwd16_lane", data_t'(last_data[i*DW +: DW]), data_t'(exp16[i]));
        y = last_data;
        drive_row(1'b1, 1'b1, TS_16, y, 1'b1, 1'b0, 1'b1, 1'b1, TS_16);
        drain();
        check("inv16_roundtrip", last_data, idx_data());

        d = rnd_data();
        drive_row(1'b1, 1'b1, TS_4, d, 1'b1, 1'b0, 1'b1, 1'b1, TS_4);
        drain();
        check("s4_passthrough", last_data, d);

        // Reset with two rows in flight
        bus.out_ready = 1'b0;
        drive_row(1'b1, 1'b0, TS_8, rnd_data(), 1'b1, 1'b0, 1'b1, 1'b0, TS_8);
        drive_row(1'b0, 1'b0, TS_8, rnd_data(), 1'b0, 1'b0, 1'b0, 1'b0, TS_8);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", data_t'(bus.out_valid), '0);
        check("midrst_in_ready", data_t'(bus.in_ready), data_t'(1'b1));
        check("midrst_out_data", bus.out_data, '0);
        sb.delete();
        held_v = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        d = rnd_data();
        drive_row(1'b0, 1'b1, TS_32, d, 1'b0, 1'b0, 1'b1, 1'b0, TS_4);
        drain();
        check("post_reset_passthrough", last_data, d);

        // Random back-pressure over 1000 rows
        lat_chk  = 1'b0;
        rand_rdy = 1'b1;
        pop0     = n_pop;
        nrow     = 0;
        while (nrow < 1000) begin
            rts  = 2'($urandom_range(0, 3));
            rinv = 1'($urandom_range(0, 1));
            s    = 4 << rts;
            for (int r = 0; r < s && nrow < 1000; r++) begin
                drive_row(r == 0, (r == 0) ? rinv : 1'($urandom), (r == 0) ? rts : 2'($urandom),
                          rnd_data(), r == 0, r == s - 1, 1'b0, rinv, rts);
                nrow++;
            end
        end
        rand_rdy      = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        check("random_row_count", data_t'(n_pop - pop0), data_t'(1000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
